// File: rtl/lru_n_way_cache_pkg.sv
// Shared types and width helpers for the set-associative LRU cache.
package lru_n_way_cache_pkg;

  // Flush sweep controller states.
  typedef enum logic [0:0] {
    StIdle,
    StFlush
  } flush_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/binenc.sv
// One-hot to binary index encoder.
module binenc #(
  parameter int unsigned N = 2,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] onehot_i,
  output logic [W-1:0] idx_o
);

  // OR together the indices of all set bits; exact for a one-hot input.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot_i[i]) idx_o = idx_o | W'(i);
    end
  end

endmodule

// File: rtl/lru_n_way_cache_lru_victim.sv
// Replacement choice: lowest-index invalid way, otherwise lowest-index way with age 0.
module lru_victim #(
  parameter int unsigned WAYS      = 2,
  parameter int unsigned AGE_WIDTH = 1
) (
  input  logic [WAYS-1:0]           valid_i,
  input  logic [WAYS*AGE_WIDTH-1:0] ages_i,
  output logic [AGE_WIDTH-1:0]      victim_o
);

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    victim_o = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (ages_i[i*AGE_WIDTH +: AGE_WIDTH] == '0) victim_o = AGE_WIDTH'(i);
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim_o = AGE_WIDTH'(i);
    end
  end

endmodule

// File: rtl/lru_n_way_cache.sv
// N-way set-associative cache with true-LRU ages, line invalidate and a per-set flush sweep.
module lru_n_way_cache
  import lru_n_way_cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  inv,
  input  logic [ADDR_WIDTH-1:0] inv_addr,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  hit,
  output logic                  busy
);

  localparam int unsigned SETS      = ENTRIES / WAYS;
  localparam int unsigned SET_WIDTH = clog2_min1(SETS);
  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - SET_WIDTH;
  localparam int unsigned AGE_WIDTH = clog2_min1(WAYS);
  localparam logic [AGE_WIDTH-1:0] MaxAge  = AGE_WIDTH'(WAYS - 1);
  localparam logic [SET_WIDTH-1:0] LastSet = SET_WIDTH'(SETS - 1);

  logic                  valid_q [SETS][WAYS];
  logic                  valid_d [SETS][WAYS];
  logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
  logic [TAG_WIDTH-1:0]  tag_d   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_d  [SETS][WAYS];
  logic [AGE_WIDTH-1:0]  age_q   [SETS][WAYS];
  logic [AGE_WIDTH-1:0]  age_d   [SETS][WAYS];

  flush_state_e          state_q, state_d;
  logic [SET_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;

  logic [SET_WIDTH-1:0] rd_set, wr_set, inv_set;
  logic [TAG_WIDTH-1:0] rd_tag, wr_tag, inv_tag;
  logic [WAYS-1:0]      rd_match, wr_match, inv_match, wr_valid;
  logic [WAYS*AGE_WIDTH-1:0] wr_ages;
  logic [AGE_WIDTH-1:0] rd_way, wr_hit_way, inv_way, victim_way, wr_way, wr_old_age, rd_age;
  logic                 idle, rd_hit, wr_hit, inv_hit, wr_en, rd_lru_en, inv_en;

  assign rd_set  = read_addr[SET_WIDTH-1:0];
  assign rd_tag  = read_addr[ADDR_WIDTH-1:SET_WIDTH];
  assign wr_set  = write_addr[SET_WIDTH-1:0];
  assign wr_tag  = write_addr[ADDR_WIDTH-1:SET_WIDTH];
  assign inv_set = inv_addr[SET_WIDTH-1:0];
  assign inv_tag = inv_addr[ADDR_WIDTH-1:SET_WIDTH];

  // Tag compare for each request port against the addressed set.
  always_comb begin
    rd_match  = '0;
    wr_match  = '0;
    inv_match = '0;
    wr_valid  = '0;
    wr_ages   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      rd_match[w]  = valid_q[rd_set][w] && (tag_q[rd_set][w] == rd_tag);
      wr_match[w]  = valid_q[wr_set][w] && (tag_q[wr_set][w] == wr_tag);
      inv_match[w] = valid_q[inv_set][w] && (tag_q[inv_set][w] == inv_tag);
      wr_valid[w]  = valid_q[wr_set][w];
      wr_ages[w*AGE_WIDTH +: AGE_WIDTH] = age_q[wr_set][w];
    end
  end

  binenc #(.N(WAYS), .W(AGE_WIDTH)) u_rd_enc  (.onehot_i(rd_match),  .idx_o(rd_way));
  binenc #(.N(WAYS), .W(AGE_WIDTH)) u_wr_enc  (.onehot_i(wr_match),  .idx_o(wr_hit_way));
  binenc #(.N(WAYS), .W(AGE_WIDTH)) u_inv_enc (.onehot_i(inv_match), .idx_o(inv_way));

  lru_victim #(.WAYS(WAYS), .AGE_WIDTH(AGE_WIDTH)) u_victim (
    .valid_i (wr_valid),
    .ages_i  (wr_ages),
    .victim_o(victim_way)
  );

  assign idle    = (state_q == StIdle);
  assign rd_hit  = |rd_match;
  assign wr_hit  = |wr_match;
  assign inv_hit = |inv_match;
  assign wr_way     = wr_hit ? wr_hit_way : victim_way;
  // A fresh allocation ranks below every valid way.
  assign wr_old_age = wr_hit ? age_q[wr_set][wr_hit_way] : '0;
  assign rd_age     = age_q[rd_set][rd_way];
  // An invalidate of the very line being written cancels the write.
  assign wr_en     = idle && we && !(inv && (inv_addr == write_addr));
  assign rd_lru_en = idle && re && rd_hit && !(we && (wr_set == rd_set));
  assign inv_en    = idle && inv && inv_hit;

  // Next state: flush sweep, or write / read-LRU / invalidate updates (invalidate applied last).
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    age_d   = age_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = idle && re && rd_hit;
    out_d   = (idle && re && rd_hit) ? data_q[rd_set][rd_way] : '0;
    if (!idle) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_d[cnt_q][w] = 1'b0;
        age_d[cnt_q][w]   = '0;
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastSet) begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end else begin
      if (flush) begin
        state_d = StFlush;
        cnt_d   = '0;
      end
      if (rd_lru_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (valid_q[rd_set][w] && (age_q[rd_set][w] > rd_age)) begin
            age_d[rd_set][w] = age_q[rd_set][w] - 1'b1;
          end
        end
        age_d[rd_set][rd_way] = MaxAge;
      end
      if (wr_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (valid_q[wr_set][w] && (age_q[wr_set][w] > wr_old_age)) begin
            age_d[wr_set][w] = age_q[wr_set][w] - 1'b1;
          end
        end
        age_d[wr_set][wr_way]   = MaxAge;
        valid_d[wr_set][wr_way] = 1'b1;
        tag_d[wr_set][wr_way]   = wr_tag;
        data_d[wr_set][wr_way]  = in;
      end
      if (inv_en) begin
        valid_d[inv_set][inv_way] = 1'b0;
        age_d[inv_set][inv_way]   = '0;
      end
    end
  end

  // State registers with asynchronous clear of the whole array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          age_q[s][w]   <= '0;
        end
      end
      state_q <= StIdle;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      age_q   <= age_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      out_q   <= out_d;
    end
  end

  assign hit  = hit_q;
  assign out  = out_q;
  assign busy = (state_q == StFlush);

endmodule

// File: doc/lru_n_way_cache.md
LRU_N_WAY_CACHE -- requirements
Module: lru_n_way_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width.
REQ-002 SHALL have parameter ENTRIES, default 8, total lines; power of 2.
REQ-003 SHALL have parameter WAYS, default 2, associativity; power of 2, >=2, ENTRIES/WAYS >= 2.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports re/we, input, 1 each, read/write request.
REQ-008 SHALL have ports read_addr/write_addr, input, ADDR_WIDTH each; low SET_WIDTH bits = set, upper bits = tag.
REQ-009 SHALL have port in, input, DATA_WIDTH, write data.
REQ-010 SHALL have ports inv, input, 1, and inv_addr, input, ADDR_WIDTH, single-line invalidate.
REQ-011 SHALL have port flush, input, 1, start full-cache invalidate.
REQ-012 SHALL have ports out, output, DATA_WIDTH, and hit, output, 1, registered read result.
REQ-013 SHALL have port busy, output, 1, flush in progress.

Function
REQ-014 Derived: SETS=ENTRIES/WAYS, SET_WIDTH=clog2(SETS), TAG_WIDTH=ADDR_WIDTH-SET_WIDTH, AGE_WIDTH=clog2(WAYS).
REQ-015 Read: re at edge N -> hit/out valid after edge N (1-cycle latency); hit=1 iff a valid way in set holds tag; out = that way's data on hit, 0 on miss; re=0 -> hit=0, out=0.
REQ-016 Read sees pre-edge state: same-cycle write to same address is not visible until the next read.
REQ-017 Write hit: overwrite data of matching way only; tag/valid unchanged.
REQ-018 Write miss: allocate lowest-index invalid way; if none, evict way with age 0 (true LRU); set valid, tag, data.
REQ-019 LRU: per-way age, AGE_WIDTH bits; ages in a set with all ways valid are a permutation of 0..WAYS-1.
REQ-020 On read hit or any write to way k with old age a: age[k]<=WAYS-1; every valid way with age>a decrements by 1; newly allocated way treated as old age 0 relative to valid ways.
REQ-021 re and we to same set in same cycle: write's LRU update applies, read's dropped; different sets: both apply.
REQ-022 inv: matching valid line cleared (valid=0, age=0); other ways' ages unchanged; no match -> no effect; inv and we to same line same cycle -> inv wins.
REQ-023 FSM states IDLE, FLUSH; IDLE->FLUSH on flush=1; FLUSH clears valid and ages of set index cnt, cnt increments each cycle; FLUSH->IDLE after set SETS-1 cleared (exactly SETS cycles).
REQ-024 busy=1 exactly in FLUSH; during busy re returns hit=0/out=0, we/inv/flush ignored, no state change besides sweep.
REQ-025 flush asserted in the last FLUSH cycle SHALL NOT restart the sweep.

Reset
REQ-026 rst SHALL asynchronously clear all valid, tag, data, age, FSM to IDLE, cnt=0, hit=0, out=0, busy=0.
REQ-027 rst mid-flush SHALL abort sweep; cache empty on release; first edge after release accepts requests.

Structure
REQ-028 Derived-width localparams and FSM state encodings SHALL live in the shared include header used by cache blocks.
REQ-029 Way-index encoding SHALL reuse the existing binenc module.
REQ-030 One sub-module lru_victim (WAYS, AGE_WIDTH) SHALL pick the victim way from valid vector and ages.

Verification (defaults: SETS=4, TAG_WIDTH=6)
REQ-031 we addr 0x04 in 0xAA; next cycle re 0x04 -> hit=1, out=0xAA; re 0x08 -> hit=0, out=0x00.
REQ-032 write 0x00=0x11, 0x04=0x22, read 0x00, write 0x08=0x33 -> read 0x04 miss; reads 0x00 (0x11) and 0x08 (0x33) hit.
REQ-033 write 0x00=0x11, then we+re 0x00 same cycle, in 0x55 -> read returns 0x11; next read returns 0x55.
REQ-034 fill all 8 lines, pulse flush -> busy=1 exactly 4 cycles; re during busy -> hit=0; all reads miss afterwards.
REQ-035 write 0x04=0x22, inv 0x04 -> read 0x04 miss; inv 0x0C (absent) leaves other lines hitting.
REQ-036 flush, rst asserted in 2nd busy cycle -> busy=0 immediately, cache empty, write+read 0x01 hits next cycles.
